// File: rtl/soc_pkg.sv
// SoC-wide OBI subordinate types and peripheral-window constants.
package soc_pkg;

  localparam int unsigned IdWidth = 4;

  // PeriphBar window: 256 x 32-bit words starting at BarAddrOffset
  localparam logic [31:0] BarAddrOffset = 32'h1000_0000;
  localparam logic [31:0] BarAddrRange  = 32'h0000_0400;
  localparam int unsigned BarNumWords   = int'(BarAddrRange >> 2);

  // rdata returned for a read that misses the window
  localparam logic [31:0] ObiErrData = 32'hBADC_AB1E;

  typedef struct packed {
    logic [31:0]        addr;
    logic               we;
    logic [3:0]         be;
    logic [31:0]        wdata;
    logic [IdWidth-1:0] aid;
  } sbr_obi_a_chan_t;

  typedef struct packed {
    sbr_obi_a_chan_t a;
    logic            req;
    logic            rready;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [31:0]        rdata;
    logic [IdWidth-1:0] rid;
    logic               err;
    logic               r_optional;
  } sbr_obi_r_chan_t;

  typedef struct packed {
    sbr_obi_r_chan_t r;
    logic            gnt;
    logic            rvalid;
  } sbr_obi_rsp_t;

  // Merge wdata into an existing word, byte lane by byte lane under be
  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/obi_sbr_mem_rsp_fifo.sv
// In-order response FIFO for the OBI subordinate memory.
module obi_rsp_fifo
  import soc_pkg::*;
#(
  parameter int unsigned Depth   = 2,
  parameter type         entry_t = sbr_obi_r_chan_t,
  localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW   = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push,
  input  entry_t          data_in,
  input  logic            pop,
  output entry_t          head,
  output logic [CntW-1:0] count
);

  localparam logic [CntW-1:0] DepthC = CntW'(Depth);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  entry_t          mem_q [Depth];
  entry_t          mem_d [Depth];
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [CntW-1:0] cnt_q,  cnt_d;
  logic            push_ok, pop_ok;

  // Pointer increment modulo Depth (Depth need not be a power of two)
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == LastPtr) return '0;
    return p + 1'b1;
  endfunction

  // Next-state for storage, pointers and occupancy
  always_comb begin
    push_ok = push && (cnt_q != DepthC);
    pop_ok  = pop && (cnt_q != '0);
    mem_d   = mem_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    cnt_d   = cnt_q;
    if (push_ok) begin
      mem_d[wptr_q] = data_in;
      wptr_d        = ptr_inc(wptr_q);
    end
    if (pop_ok) rptr_d = ptr_inc(rptr_q);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointers and count reset asynchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry storage is never reset; only entries below count are visible
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rptr_q];
  assign count = cnt_q;

endmodule

// File: rtl/obi_sbr_mem.sv
// OBI subordinate terminating a PeriphBar port: word memory plus response FIFO.
module obi_sbr_mem
  import soc_pkg::*;
#(
  parameter logic [31:0] BaseAddr = BarAddrOffset,
  parameter int unsigned NumWords = BarNumWords,
  parameter int unsigned RspDepth = 2,
  parameter logic [31:0] ErrData  = ObiErrData
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  sbr_obi_req_t obi_req_i,
  output sbr_obi_rsp_t obi_rsp_o
);

  localparam int unsigned     IdxW     = $clog2(NumWords);
  localparam int unsigned     CntW     = $clog2(RspDepth + 1);
  localparam logic [CntW-1:0] DepthC   = CntW'(RspDepth);
  localparam logic [31:0]     WinBytes = 32'(NumWords) << 2;

  logic [31:0]     mem_q [NumWords];
  logic [31:0]     mem_d [NumWords];

  logic [31:0]     off;
  logic            hit;
  logic [IdxW-1:0] idx;
  logic            gnt;
  logic            rvalid;
  logic            pop;
  logic [CntW-1:0] rsp_count;
  sbr_obi_r_chan_t push_entry;
  sbr_obi_r_chan_t head;

  // Window decode; wrap-around subtraction makes below-base addresses miss
  always_comb begin
    off = obi_req_i.a.addr - BaseAddr;
    hit = off < WinBytes;
    idx = off[IdxW+1:2];
  end

  // Handshake; gnt is masked during reset so no access can slip in while
  // the FIFO count is held at zero
  always_comb begin
    gnt    = obi_req_i.req && !rst_i && (rsp_count < DepthC);
    rvalid = (rsp_count != '0);
    pop    = rvalid && obi_req_i.rready;
  end

  // Response built from the pre-edge array word, so a read sees prior writes only
  always_comb begin
    push_entry     = '0;
    push_entry.rid = obi_req_i.a.aid;
    if (hit) begin
      push_entry.err   = 1'b0;
      push_entry.rdata = obi_req_i.a.we ? '0 : mem_q[idx];
    end else begin
      push_entry.err   = 1'b1;
      push_entry.rdata = obi_req_i.a.we ? '0 : ErrData;
    end
  end

  // Byte-enabled write of an accepted in-window store
  always_comb begin
    mem_d = mem_q;
    if (gnt && hit && obi_req_i.a.we) begin
      mem_d[idx] = be_merge(mem_q[idx], obi_req_i.a.wdata, obi_req_i.a.be);
    end
  end

  // Memory array has no reset; contents survive a reset pulse
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  obi_rsp_fifo #(
    .Depth   (RspDepth),
    .entry_t (sbr_obi_r_chan_t)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push    (gnt),
    .data_in (push_entry),
    .pop     (pop),
    .head    (head),
    .count   (rsp_count)
  );

  // Response port: r fields show the FIFO head only while rvalid
  always_comb begin
    obi_rsp_o        = '0;
    obi_rsp_o.gnt    = gnt;
    obi_rsp_o.rvalid = rvalid;
    if (rvalid) begin
      obi_rsp_o.r            = head;
      obi_rsp_o.r.r_optional = 1'b0;
    end
  end

endmodule

// File: tb/tb_obi_sbr_mem.sv
// Directed bench for obi_sbr_mem: table of single transactions plus
// back-pressure, streaming and mid-operation reset sequences.
module tb_obi_sbr_mem;
  import soc_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  sbr_obi_req_t req;
  sbr_obi_rsp_t rsp;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  obi_sbr_mem #(
    .BaseAddr (32'h1000_0000),
    .NumWords (256),
    .RspDepth (2),
    .ErrData  (32'hBADC_AB1E)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .obi_req_i (req),
    .obi_rsp_o (rsp)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata, input logic [3:0] aid);
    req.a.we    = we;
    req.a.addr  = addr;
    req.a.be    = be;
    req.a.wdata = wdata;
    req.a.aid   = aid;
  endtask

  // One transaction with rready high: granted from an empty FIFO, response
  // visible exactly one cycle after the accepting edge
  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [3:0] be, input logic [31:0] wdata, input logic [3:0] aid,
                     input logic exp_err, input logic [31:0] exp_rdata);
    @(negedge clk);
    drive_a(we, addr, be, wdata, aid);
    req.req    = 1'b1;
    req.rready = 1'b1;
    #1;
    chk({tag, " gnt"}, 32'(rsp.gnt), 32'd1);
    chk({tag, " idle rvalid"}, 32'(rsp.rvalid), 32'd0);
    @(negedge clk);
    req.req = 1'b0;
    chk({tag, " rvalid"}, 32'(rsp.rvalid), 32'd1);
    chk({tag, " rid"}, 32'(rsp.r.rid), 32'(aid));
    chk({tag, " err"}, 32'(rsp.r.err), 32'(exp_err));
    chk({tag, " rdata"}, rsp.r.rdata, exp_rdata);
    chk({tag, " ropt"}, 32'(rsp.r.r_optional), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 32'h1000_0010, 4'hF, 32'hDEAD_BEEF, 4'd1,  1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b0, 32'h1000_0010, 4'h0, 32'h0000_0000, 4'd0,  1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h1000_0010, 4'hF, 32'h1122_3344, 4'd2,  1'b0, 32'h0000_0000};
    vecs[3]  = '{1'b1, 32'h1000_0010, 4'h5, 32'hAABB_CCDD, 4'd3,  1'b0, 32'h0000_0000};
    vecs[4]  = '{1'b0, 32'h1000_0010, 4'h0, 32'h0000_0000, 4'd4,  1'b0, 32'h11BB_33DD};
    vecs[5]  = '{1'b0, 32'h1000_0013, 4'h0, 32'h0000_0000, 4'd5,  1'b0, 32'h11BB_33DD};
    vecs[6]  = '{1'b1, 32'h1000_03FC, 4'hF, 32'hCAFE_F00D, 4'd6,  1'b0, 32'h0000_0000};
    vecs[7]  = '{1'b1, 32'h1000_0000, 4'hF, 32'h0123_4567, 4'd7,  1'b0, 32'h0000_0000};
    vecs[8]  = '{1'b0, 32'h1000_0400, 4'h0, 32'h0000_0000, 4'd8,  1'b1, 32'hBADC_AB1E};
    vecs[9]  = '{1'b1, 32'h0FFF_FFFC, 4'hF, 32'hFFFF_FFFF, 4'd9,  1'b1, 32'h0000_0000};
    vecs[10] = '{1'b1, 32'h1000_0400, 4'hF, 32'hFFFF_FFFF, 4'd10, 1'b1, 32'h0000_0000};
    vecs[11] = '{1'b0, 32'h1000_03FC, 4'h0, 32'h0000_0000, 4'd11, 1'b0, 32'hCAFE_F00D};
    vecs[12] = '{1'b0, 32'h1000_0000, 4'h0, 32'h0000_0000, 4'd12, 1'b0, 32'h0123_4567};
    vecs[13] = '{1'b0, 32'h0FFF_FFFC, 4'h0, 32'h0000_0000, 4'd13, 1'b1, 32'hBADC_AB1E};
    vecs[14] = '{1'b1, 32'h1000_0004, 4'hF, 32'h5A5A_5A5A, 4'd14, 1'b0, 32'h0000_0000};
    vecs[15] = '{1'b1, 32'h1000_0004, 4'h0, 32'h1234_5678, 4'd15, 1'b0, 32'h0000_0000};
    vecs[16] = '{1'b0, 32'h1000_0004, 4'h0, 32'h0000_0000, 4'd0,  1'b0, 32'h5A5A_5A5A};

    // Reset with req held high: everything on the response port must be 0
    rst = 1'b1;
    req = '0;
    drive_a(1'b0, 32'h1000_0000, 4'hF, 32'h0, 4'd3);
    req.req    = 1'b1;
    req.rready = 1'b1;
    @(negedge clk);
    chk("reset gnt", 32'(rsp.gnt), 32'd0);
    chk("reset rvalid", 32'(rsp.rvalid), 32'd0);
    chk("reset rdata", rsp.r.rdata, 32'd0);
    chk("reset rid", 32'(rsp.r.rid), 32'd0);
    chk("reset err", 32'(rsp.r.err), 32'd0);
    rst     = 1'b0;
    req.req = 1'b0;

    // Table of single transactions
    for (int i = 0; i < 17; i++) begin
      txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata,
          vecs[i].aid, vecs[i].err, vecs[i].rdata);
    end

    // Preload words 8..10 and 16..31
    for (int k = 0; k < 3; k++) begin
      txn("preload_bp", 1'b1, 32'h1000_0020 + 32'(4 * k), 4'hF, 32'hA0A0_0008 + 32'(k),
          4'(k), 1'b0, 32'h0);
    end
    for (int k = 0; k < 16; k++) begin
      txn("preload_st", 1'b1, 32'h1000_0040 + 32'(4 * k), 4'hF, 32'hC0DE_0000 + 32'(k),
          4'(k), 1'b0, 32'h0);
    end

    // Back-pressure: FIFO fills, gnt drops, head holds, single pop reopens gnt
    @(negedge clk);
    drive_a(1'b0, 32'h1000_0020, 4'h0, 32'h0, 4'd1);
    req.req    = 1'b1;
    req.rready = 1'b0;
    #1;
    chk("bp gnt0", 32'(rsp.gnt), 32'd1);
    @(negedge clk);
    drive_a(1'b0, 32'h1000_0024, 4'h0, 32'h0, 4'd2);
    #1;
    chk("bp gnt1", 32'(rsp.gnt), 32'd1);
    chk("bp rvalid1", 32'(rsp.rvalid), 32'd1);
    chk("bp rid1", 32'(rsp.r.rid), 32'd1);
    chk("bp rdata1", rsp.r.rdata, 32'hA0A0_0008);
    @(negedge clk);
    drive_a(1'b0, 32'h1000_0028, 4'h0, 32'h0, 4'd3);
    #1;
    chk("bp full gnt", 32'(rsp.gnt), 32'd0);
    chk("bp full rvalid", 32'(rsp.rvalid), 32'd1);
    chk("bp full rid", 32'(rsp.r.rid), 32'd1);
    chk("bp full rdata", rsp.r.rdata, 32'hA0A0_0008);
    @(negedge clk);
    #1;
    chk("bp hold gnt", 32'(rsp.gnt), 32'd0);
    chk("bp hold rid", 32'(rsp.r.rid), 32'd1);
    chk("bp hold rdata", rsp.r.rdata, 32'hA0A0_0008);
    req.rready = 1'b1;
    @(negedge clk);
    req.rready = 1'b0;
    #1;
    chk("bp pop gnt", 32'(rsp.gnt), 32'd1);
    chk("bp pop rid", 32'(rsp.r.rid), 32'd2);
    chk("bp pop rdata", rsp.r.rdata, 32'hA0A0_0009);
    @(negedge clk);
    req.req    = 1'b0;
    req.rready = 1'b1;
    #1;
    chk("bp drain rid2", 32'(rsp.r.rid), 32'd2);
    @(negedge clk);
    #1;
    chk("bp drain rid3", 32'(rsp.r.rid), 32'd3);
    chk("bp drain rdata3", rsp.r.rdata, 32'hA0A0_000A);
    @(negedge clk);
    #1;
    chk("bp empty", 32'(rsp.rvalid), 32'd0);

    // Streaming: 16 back-to-back reads, one response per cycle
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      if (k < 16) begin
        drive_a(1'b0, 32'h1000_0040 + 32'(4 * k), 4'h0, 32'h0, 4'(k % 2));
        req.req = 1'b1;
      end else begin
        req.req = 1'b0;
      end
      #1;
      if (k < 16) chk($sformatf("st gnt%0d", k), 32'(rsp.gnt), 32'd1);
      if (k > 0) begin
        chk($sformatf("st rvalid%0d", k - 1), 32'(rsp.rvalid), 32'd1);
        chk($sformatf("st rid%0d", k - 1), 32'(rsp.r.rid), 32'((k - 1) % 2));
        chk($sformatf("st rdata%0d", k - 1), rsp.r.rdata, 32'hC0DE_0000 + 32'(k - 1));
      end else begin
        chk("st first rvalid", 32'(rsp.rvalid), 32'd0);
      end
    end
    @(negedge clk);
    #1;
    chk("st empty", 32'(rsp.rvalid), 32'd0);

    // Reset mid-operation with two responses pending
    @(negedge clk);
    drive_a(1'b0, 32'h1000_0040, 4'h0, 32'h0, 4'd1);
    req.req    = 1'b1;
    req.rready = 1'b0;
    @(negedge clk);
    drive_a(1'b0, 32'h1000_0044, 4'h0, 32'h0, 4'd2);
    @(negedge clk);
    #1;
    chk("rst pend rvalid", 32'(rsp.rvalid), 32'd1);
    chk("rst pend gnt", 32'(rsp.gnt), 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst async rvalid", 32'(rsp.rvalid), 32'd0);
    chk("rst async gnt", 32'(rsp.gnt), 32'd0);
    chk("rst async rid", 32'(rsp.r.rid), 32'd0);
    chk("rst async rdata", rsp.r.rdata, 32'd0);
    @(negedge clk);
    rst     = 1'b0;
    req.req = 1'b0;
    #1;
    chk("rst release rvalid", 32'(rsp.rvalid), 32'd0);
    txn("post rst w16", 1'b0, 32'h1000_0040, 4'h0, 32'h0, 4'd5, 1'b0, 32'hC0DE_0000);
    txn("post rst w4", 1'b0, 32'h1000_0010, 4'h0, 32'h0, 4'd6, 1'b0, 32'h11BB_33DD);
    txn("post rst w255", 1'b0, 32'h1000_03FC, 4'h0, 32'h0, 4'd7, 1'b0, 32'hCAFE_F00D);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
